// File: rtl/onewire_hex_tx.sv
// 1-Wire read bytes to ASCII hex over UART: byte FIFO + character FSM.
// Define ONEWIRE_HEX_CRLF_EN to end each byte with CR LF instead of a space.
module onewire_hex_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_10,
  input  logic                          arst_n,
  input  logic                          byte_vld,
  input  logic [7:0]                    byte_dat,
  input  logic                          uart_tx_busy,
  output logic                          uart_tx_write,
  output logic [7:0]                    uart_tx_data,
  input  logic                          clr_ovf,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, HI, LO, SEP, CR, LF, GAP
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    hold_q;
  logic          ovf_q;

  logic full, push, pop, drop;
  logic is_char;
  logic [7:0] chr;

  function automatic logic [7:0] hex(input logic [3:0] n);
    logic [7:0] r;
    unique case (1'b1)
      (n < 4'd10): r = 8'h30 + {4'h0, n};
      default:     r = 8'h37 + {4'h0, n};
    endcase
    return r;
  endfunction

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = (state_q == LOAD);
  assign push = byte_vld & (~full | pop);
  assign drop = byte_vld & full & ~pop;

  always_ff @(posedge clk_10) begin
    if (push) mem[wptr_q] <= byte_dat;
  end

  always_ff @(posedge clk_10 or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        hold_q <= mem[rptr_q];
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // a drop in the same cycle as a clear must leave the flag set
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_10 or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // IDLE looks at byte_vld too so a fresh byte reaches LOAD next cycle
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: if (level_q != '0 || byte_vld) state_d = LOAD;
      LOAD: state_d = HI;
      HI: if (!uart_tx_busy) begin
        state_d = GAP;
        ret_d   = LO;
      end
      LO: if (!uart_tx_busy) begin
        state_d = GAP;
`ifdef ONEWIRE_HEX_CRLF_EN
        ret_d   = CR;
`else
        ret_d   = SEP;
`endif
      end
      SEP: if (!uart_tx_busy) begin
        state_d = GAP;
        ret_d   = IDLE;
      end
      CR: if (!uart_tx_busy) begin
        state_d = GAP;
        ret_d   = LF;
      end
      LF: if (!uart_tx_busy) begin
        state_d = GAP;
        ret_d   = IDLE;
      end
      GAP:     state_d = ret_q;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_char = 1'b0;
    chr     = 8'h00;
    unique case (state_q)
      HI: begin
        is_char = 1'b1;
        chr     = hex(hold_q[7:4]);
      end
      LO: begin
        is_char = 1'b1;
        chr     = hex(hold_q[3:0]);
      end
      SEP: begin
        is_char = 1'b1;
        chr     = 8'h20;
      end
      CR: begin
        is_char = 1'b1;
        chr     = 8'h0D;
      end
      LF: begin
        is_char = 1'b1;
        chr     = 8'h0A;
      end
      default: begin
        is_char = 1'b0;
        chr     = 8'h00;
      end
    endcase
  end

  assign uart_tx_write = is_char & ~uart_tx_busy;
  assign uart_tx_data  = uart_tx_write ? chr : 8'h00;
  assign ovf           = ovf_q;
  assign level         = level_q;
  assign idle          = (state_q == IDLE) && (level_q == '0);

endmodule
